seq_detect_ctrl: RTL and testbench

Runtime-programmable Mealy sequence-detector controller for serial bit streams. It holds a configurable pattern (1 to MAX_LEN bits) and an overlap/non-overlap mode, and is armed and disarmed by start/stop commands. It emits a same-cycle match pulse and keeps a saturating match count. It replaces the fixed-pattern detectors: software configures the pattern through a valid/ready handshake and then gates detection windows around the serial input.

---
 rtl/seq_detect_ctrl.sv | 145 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Programmable Mealy sequence detector: runtime pattern/length/overlap config,
// start/stop armed detection window, same-cycle match pulse, saturating count.
//   state  | meaning
//   S_IDLE | disarmed; accepts configuration, waits for start with a valid config
//   S_RUN  | armed; evaluates each qualified serial bit against the pattern
module seq_detect_ctrl #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic               busy,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   seen_q, seen_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic               len_legal;
  logic               cfg_xfer;
  logic               match;

  assign cand      = {hist_q, in};
  assign len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign cfg_xfer  = cfg_valid && (state_q == S_IDLE);

  // Only the low cfg_len bits of the candidate window take part in the compare
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign match = (state_q == S_RUN) && in_valid &&
                 (seen_q >= (len_q - LEN_W'(1))) &&
                 (((cand ^ pat_q) & mask) == '0);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    ok_d    = ok_q;
    err_d   = 1'b0;
    hist_d  = hist_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_xfer) begin
          if (len_legal) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
            ok_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (start && ok_q) begin
          state_d = S_RUN;
          hist_d  = '0;
          seen_d  = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          if (match && !ovl_q) begin
            hist_d = '0;
            seen_d = '0;
          end else begin
            hist_d = cand[MAX_LEN-2:0];
            if (seen_q != LEN_W'(MAX_LEN)) seen_d = seen_q + LEN_W'(1);
          end
          if (match && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
          sat_d = sat_q | (&cnt_d);
        end
        if (stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      hist_q  <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out       = match;
  assign cfg_err   = err_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: bit-history reference model checked every cycle on
// two instances (8-bit and 2-bit counters), plus directed literal expectations.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, start, stop, in_valid, in_bit, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  logic       cfg_ready, cfg_err, out, busy, cnt_sat;
  logic [7:0] match_cnt;
  logic       cfg_ready2, cfg_err2, out2, busy2, cnt_sat2;
  logic [1:0] match_cnt2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(cfg_err), .start(start), .stop(stop), .in_valid(in_valid),
    .in(in_bit), .out(out), .busy(busy), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_err(cfg_err2), .start(start), .stop(stop), .in_valid(in_valid),
    .in(in_bit), .out(out2), .busy(busy2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: bits received since the window (re)started, newest last
  bit       m_run, m_ok, m_err, m_ov, m_sat8, m_sat2;
  bit [7:0] m_pat;
  int       m_len, m_cnt8, m_cnt2;
  int       hist[$];

  function automatic void m_reset();
    m_run = 0; m_ok = 0; m_err = 0; m_ov = 0; m_pat = '0; m_len = 0;
    m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 0; m_sat2 = 0;
    hist.delete();
  endfunction

  function automatic bit m_match();
    if (!m_run || !in_valid) return 0;
    if (hist.size() < m_len - 1) return 0;
    if (m_pat[0] != in_bit) return 0;
    for (int k = 1; k < m_len; k++)
      if (hist[hist.size() - k] != int'(m_pat[k])) return 0;
    return 1;
  endfunction

  function automatic void m_advance(input bit m);
    m_err = 0;
    if (!m_run) begin
      if (cfg_valid) begin
        if (cfg_len >= 1 && cfg_len <= 8) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap; m_ok = 1;
        end else m_err = 1;
      end else if (start && m_ok) begin
        m_run = 1; hist.delete();
        m_cnt8 = 0; m_cnt2 = 0; m_sat8 = 0; m_sat2 = 0;
      end
    end else begin
      if (in_valid) begin
        if (m) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt8 == 255) m_sat8 = 1;
          if (m_cnt2 < 3) m_cnt2++;
          if (m_cnt2 == 3) m_sat2 = 1;
        end
        if (m && !m_ov) hist.delete();
        else begin
          hist.push_back(int'(in_bit));
          if (hist.size() > 8) void'(hist.pop_front());
        end
      end
      if (stop) m_run = 0;
    end
  endfunction

  initial begin : compare
    bit e;
    forever begin
      @(negedge clk);
      if (!rst) m_reset();
      e = m_match();
      chk("out",        out,        e);
      chk("out2",       out2,       e);
      chk("busy",       busy,       m_run);
      chk("busy2",      busy2,      m_run);
      chk("cfg_ready",  cfg_ready,  !m_run);
      chk("cfg_err",    cfg_err,    m_err);
      chk("cfg_err2",   cfg_err2,   m_err);
      chk("match_cnt",  match_cnt,  m_cnt8);
      chk("match_cnt2", match_cnt2, m_cnt2);
      chk("cnt_sat",    cnt_sat,    m_sat8);
      chk("cnt_sat2",   cnt_sat2,   m_sat2);
      if (rst) m_advance(e);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_valid = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    tick();
    cfg_valid = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic do_stop();
    stop = 1; tick(); stop = 0;
  endtask

  task automatic send(input logic b, output logic o, output logic o2);
    in_valid = 1; in_bit = b;
    @(negedge clk); o = out; o2 = out2;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_ready", cfg_ready, 1);
    @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin : stim
    logic [13:0] pulses;
    logic [6:0]  p7;
    logic        o, o2;
    logic [13:0] s1;
    logic [6:0]  s2;

    rst = 0; cfg_valid = 0; start = 0; stop = 0; in_valid = 0; in_bit = 0;
    cfg_overlap = 0; cfg_pattern = '0; cfg_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("reset_cnt", match_cnt, 0);
    chk("reset_ready", cfg_ready, 1);

    // Non-overlapping 1101 over a 14-bit stream, first bit in s1[13]
    s1 = 14'b01011010110101;
    configure(8'b1101, 4'd4, 1'b0);
    do_start();
    chk("t1_busy", busy, 1);
    pulses = '0;
    for (int i = 0; i < 14; i++) begin
      send(s1[13-i], o, o2);
      pulses[i] = o;
    end
    chk("t1_pulses", pulses, 14'h0840);
    chk("t1_cnt", match_cnt, 2);
    do_stop();

    // 1101 over 1101101, overlapping then non-overlapping
    s2 = 7'b1101101;
    configure(8'b1101, 4'd4, 1'b1);
    do_start();
    p7 = '0;
    for (int i = 0; i < 7; i++) begin send(s2[6-i], o, o2); p7[i] = o; end
    chk("t2_ov_pulses", p7, 7'h48);
    chk("t2_ov_cnt", match_cnt, 2);
    do_stop();
    configure(8'b1101, 4'd4, 1'b0);
    do_start();
    p7 = '0;
    for (int i = 0; i < 7; i++) begin send(s2[6-i], o, o2); p7[i] = o; end
    chk("t2_nov_pulses", p7, 7'h08);
    chk("t2_nov_cnt", match_cnt, 1);
    do_stop();

    // Illegal lengths after reset: no config, start ignored
    do_reset();
    configure(8'hFF, 4'd0, 1'b0);
    chk("t3_err0", cfg_err, 1);
    configure(8'hFF, 4'd9, 1'b0);
    chk("t3_err9", cfg_err, 1);
    tick();
    chk("t3_err_clr", cfg_err, 0);
    do_start();
    chk("t3_busy", busy, 0);
    chk("t3_ready", cfg_ready, 1);

    // Stop coincident with the last bit of a match
    configure(8'b1101, 4'd4, 1'b0);
    do_start();
    send(1, o, o2); send(1, o, o2); send(0, o, o2);
    in_valid = 1; in_bit = 1; stop = 1;
    @(negedge clk);
    chk("t4_out_stop", out, 1);
    @(posedge clk); #1;
    in_valid = 0; stop = 0;
    chk("t4_busy", busy, 0);
    chk("t4_cnt", match_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      send(s2[6-i], o, o2);
      chk("t4_out_idle", o, 0);
    end
    chk("t4_cnt_hold", match_cnt, 1);

    // Length-1 pattern, 2-bit counter saturation
    configure(8'b1, 4'd1, 1'b0);
    do_start();
    for (int i = 0; i < 5; i++) begin
      send(1, o, o2);
      chk("t5_out2", o2, 1);
      chk("t5_cnt2", match_cnt2, (i < 3) ? i + 1 : 3);
      chk("t5_sat2", cnt_sat2, (i >= 2) ? 1 : 0);
    end
    chk("t5_cnt8", match_cnt, 5);
    do_stop();

    // Reset mid-pattern clears config; fresh config needed
    configure(8'b1101, 4'd4, 1'b0);
    do_start();
    send(1, o, o2); send(1, o, o2); send(0, o, o2);
    do_reset();
    do_start();
    chk("t6_start_nocfg", busy, 0);
    configure(8'b1101, 4'd4, 1'b0);
    do_start();
    send(1, o, o2);
    chk("t6_out", o, 0);
    chk("t6_cnt", match_cnt, 0);
    do_stop();

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
